// File: rtl/axi_ic_pkg.sv
// Shared definitions for the AXI interconnect B-channel ordering logic.
// Holds the slave count, the "no slave" select code and the select type.
package axi_ic_pkg;

    localparam int NUM_SLV = 5;

    typedef logic [2:0] slv_sel_t;

    localparam slv_sel_t SLV_NONE = 3'b111;

    function automatic logic sel_legal(input slv_sel_t sel);
        return sel < 3'(NUM_SLV);
    endfunction

endpackage

// File: rtl/ord_fifo.sv
// Generic circular FIFO with wrap-bit pointers, occupancy count and a head read port.
// The caller is responsible for never pushing into a full queue without a same-cycle pop.
module ord_fifo #(
    parameter int WIDTH = 9,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    localparam int        DEPTH = 2 ** AW;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_i) wptr_d = wptr_q + PTR_ONE;
        if (pop_i)  rptr_d = rptr_q + PTR_ONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q[AW-1:0]];
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign count_o = wptr_q - rptr_q;

endmodule

// File: rtl/b_resp_order_sched.sv
// Write-response ordering scheduler: queues AW targets in issue order and grants the
// B channel only to the slave whose matching response is at the head of that queue.
module b_resp_order_sched
    import axi_ic_pkg::*;
#(
    parameter int sID_width = 6,
    parameter int seq_width = 4,
    parameter int TIMEOUT   = 1024
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           aw_valid_i,
    input  logic                           aw_ready_i,
    input  logic [2:0]                     aw_slv_sel_i,
    input  logic [sID_width-1:0]           aw_id_i,
    output logic                           aw_stall_o,
    input  logic [NUM_SLV-1:0]             s_BVALID_i,
    input  logic [NUM_SLV*sID_width-1:0]   s_BID_i,
    input  logic                           m_BREADY_i,
    output logic [2:0]                     B_slv_sel_o,
    output logic                           B_grant_o,
    output logic                           B_hold_o,
    output logic [seq_width:0]             outstanding_o,
    output logic                           timeout_err_o,
    output logic                           ovf_err_o
);

    typedef struct packed {
        slv_sel_t             sel;
        logic [sID_width-1:0] id;
    } ord_entry_t;

    localparam int               AGE_W   = $clog2(TIMEOUT) + 1;
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT);
    localparam logic [AGE_W-1:0] AGE_ONE = {{(AGE_W-1){1'b0}}, 1'b1};

    ord_entry_t           head, wentry;
    logic                 full, empty, push, pop, push_req, sel_ok, ovf_set;
    logic                 head_bvalid;
    logic [sID_width-1:0] head_bid;
    logic [AGE_W-1:0]     age_q, age_d;
    logic                 ovf_q, ovf_d;

    assign push_req = aw_valid_i & aw_ready_i;
    assign sel_ok   = sel_legal(aw_slv_sel_i);
    // A full queue still accepts the push when the head pops in the same cycle.
    assign push     = push_req & sel_ok & (~full | pop);
    assign ovf_set  = push_req & (~sel_ok | (full & ~pop));
    assign wentry   = '{sel: aw_slv_sel_i, id: aw_id_i};

    ord_fifo #(
        .WIDTH ($bits(ord_entry_t)),
        .AW    (seq_width)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wentry),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (outstanding_o)
    );

    always_comb begin
        head_bvalid = 1'b0;
        head_bid    = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (head.sel == 3'(i)) begin
                head_bvalid = s_BVALID_i[i];
                head_bid    = s_BID_i[i*sID_width +: sID_width];
            end
        end
    end

    assign B_slv_sel_o = empty ? SLV_NONE : head.sel;
    assign B_grant_o   = ~empty & head_bvalid & (head_bid == head.id);
    assign B_hold_o    = B_grant_o & ~m_BREADY_i;
    assign pop         = B_grant_o & m_BREADY_i;
    assign aw_stall_o  = full;

    always_comb begin
        age_d = age_q;
        if (pop || empty)        age_d = '0;
        else if (age_q != AGE_MAX) age_d = age_q + AGE_ONE;
        ovf_d = ovf_q | ovf_set;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            age_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            age_q <= age_d;
            ovf_q <= ovf_d;
        end
    end

    assign timeout_err_o = (age_q == AGE_MAX);
    assign ovf_err_o     = ovf_q;

endmodule

// File: tb/tb_b_resp_order_sched.sv
// Directed self-checking bench for the B-response ordering scheduler (TIMEOUT shortened to 8).
module tb_b_resp_order_sched;

    localparam int ID_W  = 6;
    localparam int SEQ_W = 4;
    localparam int TMO   = 8;

    logic                clk = 1'b0;
    logic                reset;
    logic                awValid, awReady;
    logic [2:0]          awSel;
    logic [ID_W-1:0]     awId;
    logic                awStall;
    logic [4:0]          sBvalid;
    logic [5*ID_W-1:0]   sBid;
    logic                mBready;
    logic [2:0]          bSlvSel;
    logic                bGrant, bHold;
    logic [SEQ_W:0]      outstanding;
    logic                timeoutErr, ovfErr;

    int checks = 0;
    int errors = 0;

    b_resp_order_sched #(
        .sID_width (ID_W),
        .seq_width (SEQ_W),
        .TIMEOUT   (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .aw_valid_i    (awValid),
        .aw_ready_i    (awReady),
        .aw_slv_sel_i  (awSel),
        .aw_id_i       (awId),
        .aw_stall_o    (awStall),
        .s_BVALID_i    (sBvalid),
        .s_BID_i       (sBid),
        .m_BREADY_i    (mBready),
        .B_slv_sel_o   (bSlvSel),
        .B_grant_o     (bGrant),
        .B_hold_o      (bHold),
        .outstanding_o (outstanding),
        .timeout_err_o (timeoutErr),
        .ovf_err_o     (ovfErr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [2:0] sel, input logic [ID_W-1:0] id,
                                 input logic [4:0] bvalid, input logic bready);
        awValid = valid;
        awReady = valid;
        awSel   = sel;
        awId    = id;
        sBvalid = bvalid;
        mBready = bready;
    endtask

    task automatic setBid(input int slot, input logic [ID_W-1:0] id);
        sBid[slot*ID_W +: ID_W] = id;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        #1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        sBid  = '0;
        applyStimulus(1'b0, 3'd0, '0, 5'b0, 1'b1);
        #1;
        checkOutput("rst_outstanding", 32'(outstanding), 32'd0);
        checkOutput("rst_stall",       32'(awStall),     32'd0);
        checkOutput("rst_sel",         32'(bSlvSel),     32'd7);
        checkOutput("rst_grant",       32'(bGrant),      32'd0);
        checkOutput("rst_hold",        32'(bHold),       32'd0);
        checkOutput("rst_timeout",     32'(timeoutErr),  32'd0);
        checkOutput("rst_ovf",         32'(ovfErr),      32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Single write: the entry becomes visible one cycle after the push, then pops.
        @(posedge clk); #1;
        setBid(2, 6'd5);
        applyStimulus(1'b1, 3'd2, 6'd5, 5'b00100, 1'b1);
        #1;
        checkOutput("t1_no_same_cycle_sel",   32'(bSlvSel), 32'd7);
        checkOutput("t1_no_same_cycle_grant", 32'(bGrant),  32'd0);
        cycle();
        applyStimulus(1'b0, 3'd0, '0, 5'b00100, 1'b1);
        #1;
        checkOutput("t1_outstanding1", 32'(outstanding), 32'd1);
        checkOutput("t1_sel",          32'(bSlvSel),     32'd2);
        checkOutput("t1_grant",        32'(bGrant),      32'd1);
        checkOutput("t1_hold",         32'(bHold),       32'd0);
        cycle();
        applyStimulus(1'b0, 3'd0, '0, 5'b0, 1'b1);
        #1;
        checkOutput("t1_outstanding0", 32'(outstanding), 32'd0);
        checkOutput("t1_sel_none",     32'(bSlvSel),     32'd7);

        // Out-of-order responses are held back until the head slave answers.
        applyStimulus(1'b1, 3'd1, 6'd10, 5'b0, 1'b1);
        cycle();
        applyStimulus(1'b1, 3'd3, 6'd11, 5'b0, 1'b1);
        cycle();
        setBid(3, 6'd11);
        applyStimulus(1'b0, 3'd0, '0, 5'b01000, 1'b1);
        #1;
        checkOutput("t2_outstanding2", 32'(outstanding), 32'd2);
        checkOutput("t2_sel_head1",    32'(bSlvSel),     32'd1);
        checkOutput("t2_no_grant_s3",  32'(bGrant),      32'd0);
        cycle();
        checkOutput("t2_still_waiting", 32'(outstanding), 32'd2);
        setBid(1, 6'd9);
        applyStimulus(1'b0, 3'd0, '0, 5'b01010, 1'b1);
        #1;
        checkOutput("t2_id_mismatch", 32'(bGrant), 32'd0);
        setBid(1, 6'd10);
        #1;
        checkOutput("t2_grant_s1", 32'(bGrant),  32'd1);
        checkOutput("t2_sel_s1",   32'(bSlvSel), 32'd1);
        cycle();
        applyStimulus(1'b0, 3'd0, '0, 5'b01000, 1'b1);
        #1;
        checkOutput("t2_sel_s3",        32'(bSlvSel),     32'd3);
        checkOutput("t2_grant_s3",      32'(bGrant),      32'd1);
        checkOutput("t2_outstanding1",  32'(outstanding), 32'd1);
        cycle();
        applyStimulus(1'b0, 3'd0, '0, 5'b0, 1'b1);
        #1;
        checkOutput("t2_drained", 32'(outstanding), 32'd0);
        checkOutput("t2_sel_none", 32'(bSlvSel),    32'd7);

        // Fill to DEPTH, push+pop while full, then overflow.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 3'(i % 5), 6'(i), 5'b0, 1'b1);
            cycle();
        end
        applyStimulus(1'b0, 3'd0, '0, 5'b0, 1'b1);
        #1;
        checkOutput("t3_full_count", 32'(outstanding), 32'd16);
        checkOutput("t3_stall",      32'(awStall),     32'd1);
        checkOutput("t3_ovf_clear",  32'(ovfErr),      32'd0);
        setBid(0, 6'd0);
        applyStimulus(1'b1, 3'd4, 6'd20, 5'b00001, 1'b1);
        #1;
        checkOutput("t3_full_grant", 32'(bGrant), 32'd1);
        cycle();
        applyStimulus(1'b0, 3'd0, '0, 5'b0, 1'b1);
        #1;
        checkOutput("t3_pushpop_count", 32'(outstanding), 32'd16);
        checkOutput("t3_pushpop_ovf",   32'(ovfErr),      32'd0);
        checkOutput("t3_next_head",     32'(bSlvSel),     32'd1);
        applyStimulus(1'b1, 3'd0, 6'd63, 5'b0, 1'b1);
        cycle();
        applyStimulus(1'b0, 3'd0, '0, 5'b0, 1'b1);
        #1;
        checkOutput("t3_ovf_set",     32'(ovfErr),      32'd1);
        checkOutput("t3_drop_count",  32'(outstanding), 32'd16);
        doReset();
        #1;
        checkOutput("t3_reset_ovf", 32'(ovfErr), 32'd0);

        // Master back-pressure keeps the granted response held and routed.
        @(posedge clk); #1;
        applyStimulus(1'b1, 3'd3, 6'd7, 5'b0, 1'b0);
        cycle();
        setBid(3, 6'd7);
        applyStimulus(1'b0, 3'd0, '0, 5'b01000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("t4_hold",        32'(bHold),       32'd1);
            checkOutput("t4_sel_stable",  32'(bSlvSel),     32'd3);
            checkOutput("t4_no_pop",      32'(outstanding), 32'd1);
            cycle();
        end
        mBready = 1'b1;
        #1;
        checkOutput("t4_release_hold",  32'(bHold),  32'd0);
        checkOutput("t4_release_grant", 32'(bGrant), 32'd1);
        cycle();
        applyStimulus(1'b0, 3'd0, '0, 5'b0, 1'b1);
        #1;
        checkOutput("t4_popped", 32'(outstanding), 32'd0);

        // Head timeout after 8 unanswered cycles, cleared by the handshake.
        applyStimulus(1'b1, 3'd0, 6'd1, 5'b0, 1'b1);
        cycle();
        applyStimulus(1'b0, 3'd0, '0, 5'b0, 1'b1);
        repeat (7) cycle();
        checkOutput("t5_age7_quiet", 32'(timeoutErr), 32'd0);
        cycle();
        checkOutput("t5_age8_timeout", 32'(timeoutErr), 32'd1);
        cycle();
        checkOutput("t5_saturated", 32'(timeoutErr), 32'd1);
        setBid(0, 6'd1);
        applyStimulus(1'b0, 3'd0, '0, 5'b00001, 1'b1);
        #1;
        checkOutput("t5_grant", 32'(bGrant), 32'd1);
        cycle();
        applyStimulus(1'b0, 3'd0, '0, 5'b0, 1'b1);
        #1;
        checkOutput("t5_cleared", 32'(timeoutErr), 32'd0);

        // Reset mid-transfer discards all state immediately.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 3'(i), 6'(30 + i), 5'b0, 1'b0);
            cycle();
        end
        setBid(0, 6'd30);
        applyStimulus(1'b0, 3'd0, '0, 5'b00001, 1'b0);
        #1;
        checkOutput("t6_outstanding4", 32'(outstanding), 32'd4);
        checkOutput("t6_hold",         32'(bHold),       32'd1);
        reset = 1'b1;
        #1;
        checkOutput("t6_rst_outstanding", 32'(outstanding), 32'd0);
        checkOutput("t6_rst_grant",       32'(bGrant),      32'd0);
        checkOutput("t6_rst_sel",         32'(bSlvSel),     32'd7);
        @(negedge clk);
        reset = 1'b0;
        cycle();
        checkOutput("t6_late_resp_grant", 32'(bGrant),  32'd0);
        checkOutput("t6_late_resp_sel",   32'(bSlvSel), 32'd7);

        // Illegal slave select is dropped and flags overflow.
        applyStimulus(1'b1, 3'd5, 6'd1, 5'b0, 1'b1);
        cycle();
        applyStimulus(1'b0, 3'd0, '0, 5'b0, 1'b1);
        #1;
        checkOutput("t6_badsel_ovf",   32'(ovfErr),      32'd1);
        checkOutput("t6_badsel_count", 32'(outstanding), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/b_resp_order_sched.md
Name: b_resp_order_sched

Overview:
- Write-response ordering scheduler for the 5-slave B-channel crossbar.
- Records the target slave and ID of every accepted AW transaction in issue order.
- Grants the B channel only to the slave whose response is next in order, and drives the crossbar's slave-select and hold controls.
- Also reports outstanding-write occupancy, AW back-pressure, and a head-of-queue response timeout.

Parameters:
- sID_width, 6, width of slave-side BID/AWID.
- seq_width, 4, log2 of ordering-queue depth (DEPTH = 2**seq_width outstanding writes).
- TIMEOUT, 1024, cycles a head entry may wait for its response before timeout_err asserts; must be ≥2.

Ports:
- clk, input, 1, system clock, rising edge.
- reset, input, 1, asynchronous active-high reset.
- aw_valid, input, 1, master AWVALID, observed.
- aw_ready, input, 1, AWREADY as seen by master, observed; push = aw_valid & aw_ready.
- aw_slv_sel, input, 3, decoded target slave of the AW beat (0..4).
- aw_id, input, sID_width, slave-side ID of the AW beat.
- aw_stall, output, 1, queue full; AW decoder gates AWREADY with it.
- s_BVALID, input, 5, BVALID of slaves 4..0 (bit i = slave i).
- s_BID, input, 5*sID_width, BID of slaves 4..0 packed; slave i at [i*sID_width +: sID_width].
- m_BREADY, input, 1, master BREADY.
- B_slv_sel, output, 3, slave routed by the crossbar; 3'b111 = none.
- B_grant, output, 1, routed slave holds a matching valid response this cycle.
- B_hold, output, 1, granted response stalled by master (B_grant & ~m_BREADY).
- outstanding, output, seq_width+1, number of queued writes.
- timeout_err, output, 1, head entry has waited TIMEOUT cycles.
- ovf_err, output, 1, sticky: push attempted while full, or aw_slv_sel > 4.

Behaviour:
Reset (asynchronous, active-high):
- Queue empty; outstanding = 0; aw_stall = 0; B_slv_sel = 3'b111.
- B_grant, B_hold, timeout_err, ovf_err = 0; age counter = 0.

Queue:
- Circular FIFO of DEPTH entries {sel[2:0], id}, with read/write pointers of seq_width+1 bits (wrap bit).
- Full when pointers differ only in the MSB; empty when equal.
- Push on aw_valid & aw_ready & ~full & (aw_slv_sel ≤ 4). The entry is visible at the head the next cycle (1-cycle latency), never in the same cycle.
- Pop on B_grant & m_BREADY (B handshake). The next entry is at the head the following cycle.
- Simultaneous push and pop: both take effect and outstanding is unchanged. This is legal when full (no overflow, since the push is gated by the registered full only if the pop is absent). Push while full is accepted only when a pop occurs the same cycle.
- Push while full without a pop: dropped, ovf_err set.
- aw_slv_sel > 4: dropped, ovf_err set.
- ovf_err clears only on reset.
- aw_stall = full (registered-state decode, combinational output).

Grant (combinational from head registers and slave inputs):
- B_slv_sel = head.sel when not empty, else 3'b111.
- B_grant = ~empty & s_BVALID[head.sel] & (s_BID[head.sel] == head.id).
- A valid response from a non-head slave, or with a mismatched ID, is not granted; that slave's BREADY stays low through the crossbar.
- B_hold = B_grant & ~m_BREADY. Once B_grant is high, head and B_slv_sel are stable until the pop (AXI valid-stability).

Timeout:
- age counter (width clog2(TIMEOUT)+1) clears on pop, when empty, and on reset.
- Otherwise it increments each cycle and saturates at TIMEOUT.
- timeout_err = (age == TIMEOUT); level output, deasserts the cycle after the pop.

Reset mid-transfer:
- All state is discarded immediately.
- Outstanding responses arriving after reset are never granted.

Decomposition:
- Shared package axi_ic_pkg:
  - NUM_SLV = 5
  - SLV_NONE = 3'b111
  - typedef slv_sel_t (logic [2:0])
  - typedef struct ord_entry_t {slv_sel_t sel; logic [sID_width-1:0] id} (parameterised via localparam in the module)
- One natural sub-module, ord_fifo: a generic synchronous FIFO with full/empty/count and a head read port. The scheduler wraps it with the grant, timeout and error logic.

Test Plan:
1. Reset, then push {sel=2,id=5}; s_BVALID[2]=1, s_BID slot2=5, m_BREADY=1 -> B_slv_sel=2, B_grant=1 the cycle after push; pop; outstanding 1->0; B_slv_sel=3'b111.
2. Push sel=1 then sel=3; slave 3 responds first -> B_grant=0 and B_slv_sel=1 until slave 1 responds; then slave 1 is granted, then slave 3; order preserved.
3. Push DEPTH (16) entries -> aw_stall=1, outstanding=16. Push again without a pop -> dropped, ovf_err=1. Same-cycle push and pop when full -> outstanding stays 16, ovf_err unchanged.
4. Granted response with m_BREADY=0 for 3 cycles -> B_hold=1 for 3 cycles, B_slv_sel stable; pop on the cycle m_BREADY=1.
5. TIMEOUT=8, head entry with no response -> timeout_err=1 at age 8; response then handshake -> timeout_err=0 the next cycle.
6. Reset asserted with 4 outstanding while B_hold=1 -> same-cycle outstanding=0, B_grant=0, B_slv_sel=3'b111; slave BVALID after deassert is not granted.
